// File: rtl/fifo_pkg.sv
// Shared types, defaults and Gray-code helpers for the async FIFO controllers.
package fifo_pkg;

  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DATA_W = 8;
  localparam int PTR_W      = DEF_ADDR_W + 1;

  typedef enum logic {
    ST_IDLE,
    ST_FULL
  } out_state_t;

  // Helpers work on 32-bit vectors; callers size-cast the result down to their pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Multi-flop vector synchronizer for Gray pointers crossing clock domains.
// The input feeds the first flop directly; STAGES must be at least 2.
module fifo_ptr_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO with a registered show-ahead output stage.
// Optional macro RD_LEVEL_EN adds a registered 'level' output (entries still in RAM).
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W:0]   wptr_gray,
  output logic [ADDR_W:0]   rptr_gray,
  output logic [ADDR_W-1:0] rd_adr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
`ifdef RD_LEVEL_EN
  output logic [ADDR_W:0]   level,
`endif
  output logic              empty
);

  localparam int PW = ADDR_W + 1;

  logic [ADDR_W:0] wptr_s;
  logic [ADDR_W:0] rbin;
  logic [ADDR_W:0] rbin_next;
  logic            pop;
  out_state_t      state;
  out_state_t      state_next;

  fifo_ptr_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .clk (clk),
    .rst (rst),
    .d   (wptr_gray),
    .q   (wptr_s)
  );

  // Both operands are registers, so empty is glitch-free within the cycle.
  assign empty     = (wptr_s == rptr_gray);
  assign out_valid = (state == ST_FULL);
  assign rd_adr    = rbin[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A pop refills the output register whenever it is free or being drained this cycle.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    rbin_next  = rbin;
    unique case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          if (!empty) begin
            pop = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (pop) begin
      rbin_next = rbin + {{ADDR_W{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rbin      <= '0;
      rptr_gray <= '0;
      out_data  <= '0;
    end else begin
      rbin      <= rbin_next;
      rptr_gray <= PW'(bin2gray(32'(rbin_next)));
      if (pop) begin
        out_data <= ram_rd_data;
      end
    end
  end

`ifdef RD_LEVEL_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level <= '0;
    end else begin
      level <= PW'(gray2bin(32'(wptr_s))) - rbin_next;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: directed scenarios plus a randomized scoreboard stream.
// Define RD_LEVEL_EN on both RTL and bench to exercise the level output.
module tb_fifo_rd_ctrl;

  localparam int ADDR_W      = 3;
  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;
  localparam int DEPTH       = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W:0]   wptr_gray;
  logic [ADDR_W:0]   rptr_gray;
  logic [ADDR_W-1:0] rd_adr;
  logic [DATA_W-1:0] ram_rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              empty;
`ifdef RD_LEVEL_EN
  logic [ADDR_W:0]   level;
`endif

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] exp_q [$];
  logic [ADDR_W:0]   prev_rptr;
  int checks  = 0;
  int errors  = 0;
  int wbin    = 0;
  int accepts = 0;
  bit mon_en  = 1'b0;

  always #5 clk = ~clk;

  assign ram_rd_data = mem[rd_adr];

  fifo_rd_ctrl #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wptr_gray   (wptr_gray),
    .rptr_gray   (rptr_gray),
    .rd_adr      (rd_adr),
    .ram_rd_data (ram_rd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
`ifdef RD_LEVEL_EN
    .level       (level),
`endif
    .empty       (empty)
  );

  // Gray code of a pointer count modulo 2*DEPTH.
  function automatic logic [ADDR_W:0] to_gray(input int n);
    logic [ADDR_W:0] b;
    b = (ADDR_W+1)'(n % (2 * DEPTH));
    return b ^ (b >> 1);
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic apply_reset();
    mon_en    = 1'b0;
    rst       = 1'b0;
    out_ready = 1'b0;
    wbin      = 0;
    accepts   = 0;
    wptr_gray = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Publish a new write count (as the write domain would) at mid-cycle.
  task automatic apply_stimulus(input int new_wbin, input logic ready);
    @(negedge clk);
    wbin      = new_wbin;
    wptr_gray = to_gray(new_wbin);
    out_ready = ready;
  endtask

  // Monitor: pops the scoreboard on every accept and checks pointer behaviour.
  always @(negedge clk) begin
    if (mon_en && rst) begin
      check_output("rptr_vs_model", 32'(rptr_gray), 32'(to_gray(accepts + int'(out_valid))));
      if (rptr_gray != prev_rptr) begin
        check_output("rptr_hamming", 32'($countones(rptr_gray ^ prev_rptr)), 32'd1);
      end
      prev_rptr = rptr_gray;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL scoreboard_underflow actual=%0h expected=none", out_data);
        end else begin
          check_output("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
        accepts++;
      end
    end
  end

  // Random writer + random consumer; writer never lets RAM occupancy reach DEPTH.
  task automatic run_stream(input int nwords, input int ready_pct);
    int cyc;
    cyc       = 0;
    prev_rptr = '0;
    mon_en    = 1'b1;
    while ((accepts < nwords) && (cyc < 4000)) begin
      @(posedge clk);
      #1;
      cyc++;
      out_ready = ($urandom_range(99) < ready_pct);
      if ((wbin < nwords) && ((wbin - accepts) < DEPTH) && ($urandom_range(1) == 1)) begin
        logic [DATA_W-1:0] w;
        w = DATA_W'($urandom);
        mem[wbin % DEPTH] = w;
        exp_q.push_back(w);
        wbin++;
        wptr_gray = to_gray(wbin);
      end
    end
    mon_en = 1'b0;
    check_output("stream_done", 32'(accepts), 32'(nwords));
    check_output("stream_queue_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check_output("stream_final_rptr", 32'(rptr_gray), 32'(to_gray(nwords)));
    check_output("stream_final_empty", 32'(empty), 32'd1);
    check_output("stream_final_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int n;
    int empty_edge;
    logic [ADDR_W:0] seq [7];
    seq = '{4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    rst       = 1'b0;
    out_ready = 1'b0;
    wptr_gray = '0;
    prev_rptr = '0;

    // Reset state
    #1;
    check_output("reset_rptr", 32'(rptr_gray), 32'd0);
    check_output("reset_adr", 32'(rd_adr), 32'd0);
    check_output("reset_valid", 32'(out_valid), 32'd0);
    check_output("reset_empty", 32'(empty), 32'd1);
    check_output("reset_data", 32'(out_data), 32'd0);

    // Single word with two-stage sync latency
    apply_reset();
    mem[0] = 8'hA5;
    apply_stimulus(1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_output("single_empty_low", 32'(empty), 32'd0);
    check_output("single_valid_low", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check_output("single_valid", 32'(out_valid), 32'd1);
    check_output("single_data", 32'(out_data), 32'hA5);
    check_output("single_rptr", 32'(rptr_gray), 32'b0001);
    check_output("single_adr", 32'(rd_adr), 32'd1);
    check_output("single_empty", 32'(empty), 32'd1);

    // Backpressure then full-rate drain
    apply_reset();
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h10 + 8'(i);
    apply_stimulus(8, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    check_output("bp_rptr_hold", 32'(rptr_gray), 32'b0001);
    check_output("bp_data_hold", 32'(out_data), 32'h10);
    check_output("bp_valid_hold", 32'(out_valid), 32'd1);
    @(negedge clk);
    out_ready = 1'b1;
    for (int k = 1; k < DEPTH; k++) begin
      @(posedge clk);
      #1;
      check_output("drain_data", 32'(out_data), 32'h10 + 32'(k));
      check_output("drain_rptr", 32'(rptr_gray), 32'(seq[k-1]));
    end
    check_output("drain_empty", 32'(empty), 32'd1);
    check_output("drain_valid_last", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    check_output("drain_valid_drop", 32'(out_valid), 32'd0);

    // Asynchronous reset in the middle of a held word
    apply_reset();
    mem[0] = 8'h5A;
    apply_stimulus(1, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_output("midrst_rptr", 32'(rptr_gray), 32'd0);
    check_output("midrst_adr", 32'(rd_adr), 32'd0);
    check_output("midrst_valid", 32'(out_valid), 32'd0);
    check_output("midrst_empty", 32'(empty), 32'd1);
    check_output("midrst_data", 32'(out_data), 32'd0);

    // Pointer latency from a mid-cycle write-pointer change
    apply_reset();
    mem[0] = 8'h3C;
    apply_stimulus(1, 1'b1);
    n = 0;
    empty_edge = 0;
    while (!out_valid && (n < 20)) begin
      @(posedge clk);
      #1;
      n++;
      if (!empty && (empty_edge == 0)) empty_edge = n;
    end
    check_output("lat_empty_edges", 32'(empty_edge), 32'(SYNC_STAGES));
    check_output("lat_valid_edges", 32'(n), 32'(SYNC_STAGES + 1));
    check_output("lat_data", 32'(out_data), 32'h3C);

    // Randomized streams through the pointer wrap
    apply_reset();
    run_stream(20, 60);
    apply_reset();
    run_stream(37, 100);

`ifdef RD_LEVEL_EN
    apply_reset();
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h20 + 8'(i);
    apply_stimulus(4, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_output("level_first", 32'(level), 32'd3);
    check_output("level_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("level_zero", 32'(level), 32'd0);
    check_output("level_empty", 32'(empty), 32'd1);
    check_output("level_data", 32'(out_data), 32'h23);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Read-side controller of the async FIFO, running in the read clock domain. Consumes the write-domain Gray pointer and synchronizes it. Owns the read Gray counter, drives the RAM read address and produces the empty flag. Presents data through a registered show-ahead valid/ready output stage, and returns its own Gray pointer to the write side for full detection.

Parameters:
ADDR_W, 3, RAM address width; pointers are ADDR_W+1 bits (extra wrap bit); depth 2**ADDR_W
DATA_W, 8, data width
SYNC_STAGES, 2, flop stages on the incoming write pointer (minimum 2)

Ports:
clk  in  1  read-domain clock
rst  in  1  reset, asynchronous, active-low
wptr_gray  in  ADDR_W+1  write pointer, Gray, from write domain (asynchronous)
rptr_gray  out  ADDR_W+1  read pointer, Gray, registered, to write-domain synchronizer
rd_adr  out  ADDR_W  binary RAM read address
ram_rd_data  in  DATA_W  RAM read data at rd_adr (asynchronous read, same cycle)
out_valid  out  1  output register holds a word
out_ready  in  1  consumer accepts word when out_valid & out_ready
out_data  out  DATA_W  output word
empty  out  1  no unread entries in RAM (output register not counted)

Behaviour:
- Reset (rst=0, async): sync chain=0, rbin=0, rptr_gray=0, rd_adr=0, out_valid=0, out_data=0, empty=1.
- wptr_gray passes through SYNC_STAGES flops -> wptr_s. No logic ahead of the first flop.
- Binary counter rbin[ADDR_W:0]:
  - rd_adr = rbin[ADDR_W-1:0].
  - rptr_gray is a register loaded with bin2gray(rbin_next), so it is glitch-free and changes exactly 1 bit per increment.
- empty = (wptr_s == rptr_gray). Combinational from registers only.
- pop = !empty & (!out_valid | out_ready).
  - On pop: out_data <= ram_rd_data, out_valid <= 1, rbin <= rbin+1 (wraps mod 2**(ADDR_W+1)).
  - Else if out_valid & out_ready: out_valid <= 0.
  - Else: hold.
- Output stage states:
  - IDLE (out_valid=0) -> FULL on pop.
  - FULL -> FULL on accept+pop (back-to-back, 1 word/cycle).
  - FULL -> IDLE on accept with empty.
  - FULL holds while out_ready=0; out_data stable.
- Latency: wptr_gray change -> empty deasserts after SYNC_STAGES edges -> out_valid on the next edge (SYNC_STAGES+1 total).
- Simultaneous accept and pop: new word replaces the old in the same edge, no bubble.
- Pointer wrap: the 1000->0000 transition (ADDR_W=3) is an ordinary single-bit step. Empty compare includes the wrap bit.
- out_ready while out_valid=0 is ignored.
- Reset mid-operation discards the output word. Pointers return to 0; the write side must be reset in the same reset episode.

Optional Feature:
Macro RD_LEVEL_EN.
- Defined: adds output level[ADDR_W:0], registered = gray2bin(wptr_s) - rbin_next, mod 2**(ADDR_W+1). It counts entries still in RAM, excluding the output register. Reset value 0.
- Undefined: no port, no logic; all other behaviour identical.

Decomposition:
- Shared package fifo_pkg:
  - bin2gray and gray2bin functions
  - default ADDR_W/DATA_W
  - pointer width constant PTR_W = ADDR_W+1
- One sub-module, fifo_ptr_sync: SYNC_STAGES-deep vector synchronizer with async active-low reset. It is reused by the write side.

Test Plan:
1. Reset: rst=0 during operation -> immediately rptr_gray=0000, rd_adr=000, out_valid=0, empty=1.
2. Single word: RAM[0]=0xA5, wptr_gray 0000->0001, out_ready=0 -> empty=0 after 2 edges; 3rd edge out_valid=1, out_data=A5, rptr_gray=0001, rd_adr=001, empty=1.
3. Backpressure: RAM[0..7]=0x10..0x17, wptr_gray=1100, out_ready=0:
   - Exactly one pop; rptr_gray holds 0001, out_data=10.
   - Then out_ready=1: out_data 11..17 on consecutive edges.
   - rptr_gray steps 0011,0010,0110,0111,0101,0100,1100, then empty=1.
   - out_valid drops one edge after the last accept.
4. Wrap: 16 words streamed with random out_ready -> rptr_gray passes 1000->0000; data order preserved; each rptr_gray change has Hamming distance 1; no pop while empty.
5. Sync latency: wptr_gray changes mid-cycle while out_ready=1 -> out_valid asserts no earlier than SYNC_STAGES+1 edges; no read of unwritten address.
6. RD_LEVEL_EN: wptr_gray=0110 (bin 4), out_ready=0 -> after first pop level=3, out_valid=1; after 3 more accepts+pops level=0, empty=1.
